// File: rtl/shift_add_multiplier.sv
// Purpose: 8x8 unsigned shift-add multiplier. Each step adds through an external 8-bit adder.
// Latency: Done is high in the 9th cycle after the accepting edge, or the 1st cycle with MULT_ZERO_SKIP_EN and a zero operand.
// Backpressure: Ready is high only in IDLE, and Start is ignored outside IDLE. Done is a one-cycle pulse with no stall.
// Build option: define MULT_ZERO_SKIP_EN so that a zero operand skips BUSY and goes straight to DONE.

module shift_add_multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        Ready,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Product,
    output logic [7:0]  AddA,
    output logic [7:0]  AddB,
    input  logic [7:0]  AddSum,
    input  logic        AddCout
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  m;          // multiplicand
    logic [7:0]  q;          // multiplier, shifted out as the low product shifts in
    logic [7:0]  acc;        // high half of the partial product
    logic        c;          // carry above acc; always cleared after each step
    logic [2:0]  cnt;        // step counter, 0..7
    logic [15:0] product;

    logic [7:0]  acc_shift;
    logic [7:0]  q_shift;
    logic        accept;
    logic        last_step;

`ifdef MULT_ZERO_SKIP_EN
    logic        zero_op;
    assign zero_op = (A == 8'd0) || (B == 8'd0);
`endif

    assign accept    = (state == IDLE) && Start;
    assign last_step = (state == BUSY) && (cnt == 3'd7);

    // The adder always sees the high partial product and the multiplicand.
    assign AddA    = acc;
    assign AddB    = m;
    assign Product = product;

    // The handshake outputs depend on the state alone, so exactly one of them is high.
    assign Ready = (state == IDLE);
    assign Busy  = (state == BUSY);
    assign Done  = (state == DONE);

    // One step: add M to the partial product if Q[0] is set, then shift {carry, acc, q} right by one.
    always_comb begin
        acc_shift = {c, acc[7:1]};
        q_shift   = {acc[0], q[7:1]};
        if (q[0]) begin
            acc_shift = {AddCout, AddSum[7:1]};
            q_shift   = {AddSum[0], q[7:1]};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: IDLE waits for Start, BUSY runs 8 steps, and DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) begin
`ifdef MULT_ZERO_SKIP_EN
                    state_nxt = zero_op ? DONE : BUSY;
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                if (cnt == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load the operands on accept, step once per BUSY cycle, and latch Product on the last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m       <= 8'd0;
            q       <= 8'd0;
            acc     <= 8'd0;
            c       <= 1'b0;
            cnt     <= 3'd0;
            product <= 16'd0;
        end else begin
            if (accept) begin
                m   <= A;
                q   <= B;
                acc <= 8'd0;
                c   <= 1'b0;
                cnt <= 3'd0;
`ifdef MULT_ZERO_SKIP_EN
                if (zero_op) begin
                    product <= 16'd0;
                end
`endif
            end else if (state == BUSY) begin
                acc <= acc_shift;
                q   <= q_shift;
                c   <= 1'b0;
                cnt <= cnt + 3'd1;
                if (last_step) begin
                    product <= {acc_shift, q_shift};
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Purpose: randomized self-checking bench for shift_add_multiplier with an 8-bit ripple-carry adder attached.
// Latency: the expected latency is 9 cycles from acceptance to Done, or 1 cycle for a zero operand with MULT_ZERO_SKIP_EN.
// Backpressure: a new Start is offered only once Ready is seen, and back-to-back starts are issued on the earliest legal edge.

module tb_shift_add_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_sum;
    logic        add_cout;

    int checks   = 0;
    int failures = 0;
    logic [15:0] last_p;

    shift_add_multiplier dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (start),
        .A       (a),
        .B       (b),
        .Ready   (ready),
        .Busy    (busy),
        .Done    (done),
        .Product (product),
        .AddA    (add_a),
        .AddB    (add_b),
        .AddSum  (add_sum),
        .AddCout (add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 8-bit ripple-carry adder with carry-in tied to 0.
    function automatic logic [8:0] ripple_add(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] s;
        logic       cy;
        cy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s[i] = x[i] ^ y[i] ^ cy;
            cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
        end
        return {cy, s};
    endfunction

    always_comb begin
        {add_cout, add_sum} = ripple_add(add_a, add_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one multiply. The caller is #1 after an edge with the DUT idle, and the task returns #1 after an edge with the DUT idle again.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit hold);
        logic [15:0] exp_p;
        int          exp_lat;
        int          lat;
        int          busy_n;
        bit          seen;
        bit          prod_moved;
        bit          onehot_ok;
        bit          m_ok;

        exp_p   = 16'(x) * 16'(y);
        exp_lat = 9;
`ifdef MULT_ZERO_SKIP_EN
        if (x == 8'd0 || y == 8'd0) exp_lat = 1;
`endif
        check("ready_before", ready, 1);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        // Operands change right after acceptance and must have no effect.
        a = 8'($urandom);
        b = 8'($urandom);
        if (!hold) start = 1'b0;

        lat = 0; busy_n = 0; seen = 0; prod_moved = 0; onehot_ok = 1; m_ok = 1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (int'(ready) + int'(busy) + int'(done) != 1) onehot_ok = 0;
            if (busy) begin
                busy_n++;
                if (product !== last_p) prod_moved = 1;
                if (add_b !== x) m_ok = 0;
            end
            if (done) begin
                seen = 1;
                lat  = k;
            end else begin
                @(posedge clk); #1;
                if (hold) begin
                    a = 8'($urandom);
                    b = 8'($urandom);
                end
            end
        end
        check("done_seen", seen, 1);
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_n, (exp_lat == 1) ? 0 : 8);
        check("product", product, exp_p);
        check("onehot", onehot_ok, 1);
        check("product_stable_busy", prod_moved, 0);
        check("addb_is_m", m_ok, 1);
        last_p = exp_p;

        // Done lasts exactly one cycle, and the DUT returns to IDLE even if Start is still high.
        @(posedge clk); #1;
        check("done_width", done, 0);
        check("ready_after", ready, 1);
        check("product_hold", product, exp_p);
        if (hold) begin
            start = 1'b0;
            @(posedge clk); #1;
            check("no_restart", busy | done, 0);
        end
    endtask

    initial begin
        int dn;
        logic [7:0] rx;
        logic [7:0] ry;

        reset  = 1'b1;
        start  = 1'b0;
        a      = 8'd0;
        b      = 8'd0;
        last_p = 16'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_adda", add_a, 0);
        check("rst_addb", add_b, 0);
        #4 reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'd13, 8'd11, 0);
        run_op(8'h80, 8'h02, 0);
        run_op(8'h5A, 8'h00, 0);
        run_op(8'h00, 8'h37, 0);
        run_op(8'hC3, 8'h5D, 1);

        // Asynchronous reset in the middle of the 4th BUSY cycle.
        run_op(8'hFF, 8'hFF, 0);
        start = 1'b1; a = 8'd7; b = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_product", product, 0);
        #1 reset = 1'b0;
        last_p = 16'd0;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        run_op(8'd3, 8'd5, 0);

        // Random operand pairs, with about one in eight operands forced to 0 or 0xFF.
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rx = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 7) == 0) ry = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            run_op(rx, ry, ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be, clock and reset first:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Start  input  1  request to begin a multiply
- A  input  8  multiplicand, sampled with Start
- B  input  8  multiplier, sampled with Start
- Ready  output  1  high only in IDLE
- Busy  output  1  high only in BUSY
- Done  output  1  one-cycle completion pulse
- Product  output  16  unsigned A*B
- AddA  output  8  to external 8-bit adder operand A
- AddB  output  8  to external 8-bit adder operand B
- AddSum  input  8  from external adder Sum (adder carry-in tied 0)
- AddCout  input  1  from external adder Cout
REQ-003 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 The FSM SHALL have states IDLE, BUSY and DONE, encoded in 2 bits.
REQ-005 Internal registers SHALL be M[7:0] (multiplicand), Q[7:0] (multiplier/low product), Acc[7:0] (high product), C (1 bit) and Cnt[2:0].
REQ-006 IDLE with Start=1 at an edge SHALL load M=A, Q=B, Acc=0, C=0 and Cnt=0, and move to BUSY.
REQ-007 Start SHALL be ignored in BUSY and DONE; A and B are sampled only on the accepting edge.
REQ-008 AddA SHALL equal Acc and AddB SHALL equal M, combinationally, in all states.
REQ-009 On each BUSY edge:
- if Q[0]=1: {C,Acc,Q} <= {1'b0, AddCout, AddSum, Q[7:1]}
- otherwise: {C,Acc,Q} <= {1'b0, 1'b0, Acc, Q[7:1]}
- in both cases Cnt <= Cnt+1
REQ-010 The BUSY edge with Cnt==7 SHALL latch Product <= the shifted {Acc,Q} value and move to DONE; BUSY therefore lasts exactly 8 cycles.
REQ-011 DONE SHALL last one cycle with Done=1, then return to IDLE unconditionally.
REQ-012 Done SHALL be high in the 9th cycle after the Start-accepting edge, and the next Start is accepted no earlier than the following edge.
REQ-013 Product SHALL hold its value from one DONE until the next Product update and SHALL NOT change during BUSY.
REQ-014 Arithmetic SHALL be unsigned with no overflow, since the 16-bit Product covers 0xFF*0xFF = 0xFE01.
REQ-015 Ready, Busy and Done SHALL be decoded from state only; exactly one of them is high in any cycle.

Reset
REQ-016 While reset=1 the block SHALL be in IDLE, and all registers and Product SHALL be 0, independent of clk.
REQ-017 After reset: Ready=1, Busy=0, Done=0, AddA=0, AddB=0.
REQ-018 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation with no Done pulse and clear Product to 0.

Configuration
REQ-019 Macro MULT_ZERO_SKIP_EN SHALL control early exit on a zero operand.
REQ-020 With MULT_ZERO_SKIP_EN defined: an accepted Start with A==0 or B==0 SHALL set Product=0 and go straight IDLE->DONE, so Done is high the cycle after acceptance and BUSY is never entered.
REQ-021 Without MULT_ZERO_SKIP_EN: zero operands SHALL take the full 8-cycle BUSY path and produce Product=0 per REQ-010.

Verification
REQ-022 The bench SHALL connect an 8-bit ripple-carry adder with carry-in 0 to AddA/AddB/AddSum/AddCout and cover these scenarios:
- A=0xFF, B=0xFF, Start pulse -> Busy 8 cycles, Done in cycle 9, Product=0xFE01
- A=13, B=11 -> Product=0x008F; then A=0x80, B=0x02 back-to-back -> Product=0x0100
- A=0x5A, B=0x00: with macro, Done the cycle after Start and Product=0; without macro, Done in cycle 9 and Product=0
- Start held high through BUSY with A/B changing -> result uses only the first-sampled operands; no second Done until Start is re-sampled in IDLE
- reset pulsed asynchronously mid-BUSY (cycle 4) -> immediate IDLE, Product=0, no Done; next op 3*5 -> Product=15
- Random 1000 operand pairs -> Product equals A*B and Done width is exactly 1 cycle
